// File: rtl/osc_freq_counter_if.sv
// rtl/osc_freq_counter_if.sv - control/status bundle for the oscillator frequency counter
interface osc_freq_counter_if #(
  parameter int CNT_W = 16
);
  logic             ena;
  logic             start;
  logic             cont;
  logic [2:0]       gate_sel;
  logic [CNT_W-1:0] result;
  logic             done;
  logic             busy;
  logic             overflow;

  // Controller side: issues commands, observes results
  modport master (
    output ena, start, cont, gate_sel,
    input  result, done, busy, overflow
  );

  // Counter side: receives commands, presents results
  modport slave (
    input  ena, start, cont, gate_sel,
    output result, done, busy, overflow
  );
endinterface

// File: rtl/osc_freq_counter.sv
// rtl/osc_freq_counter.sv - gated rising-edge counter for an asynchronous oscillator tap
module osc_freq_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_BASE   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                osc_in,
  osc_freq_counter_if.slave   bus
);

  // Window counter wide enough for the longest window, 2^(GATE_BASE+7) cycles
  localparam int WIN_W = GATE_BASE + 8;
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [WIN_W-1:0] WIN_BASE = WIN_ONE << GATE_BASE;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_GATE = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_stb;

  logic [2:0]       gsel_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_int_q;

  logic [CNT_W-1:0] result_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;

  logic gsel_load;
  logic arm_load;
  logic gate_run;
  logic done_fire;
  logic busy_d;

  // Bring the oscillator tap into the clk domain and keep one cycle of history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_stb = sync_q[SYNC_STAGES-1] & ~hist_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping ena abandons whatever is in flight
  always_comb begin
    state_d = state_q;
    if (!bus.ena) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (bus.start) state_d = S_ARM;
        S_ARM:   state_d = S_GATE;
        S_GATE:  if (win_q == '0) state_d = S_DONE;
        S_DONE:  state_d = bus.cont ? S_ARM : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath strobes and the next value of busy
  always_comb begin
    gsel_load = (state_q != S_ARM) && (state_d == S_ARM);
    arm_load  = (state_q == S_ARM);
    gate_run  = (state_q == S_GATE);
    done_fire = (state_q == S_DONE) && bus.ena;
    busy_d    = (state_d == S_ARM) || (state_d == S_GATE);
  end

  // Measurement datapath: window countdown and saturating edge count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gsel_q    <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
    end else begin
      if (gsel_load) begin
        gsel_q <= bus.gate_sel;
      end
      if (arm_load) begin
        cnt_q     <= '0;
        ovf_int_q <= 1'b0;
        win_q     <= (WIN_BASE << gsel_q) - WIN_ONE;
      end else if (gate_run) begin
        win_q <= win_q - WIN_ONE;
        if (edge_stb) begin
          if (cnt_q == CNT_MAX) begin
            ovf_int_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Registered result, flags and status presented to the readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= done_fire;
      busy_q <= busy_d;
      if (done_fire) begin
        result_q <= cnt_q;
        ovf_q    <= ovf_int_q;
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_osc_freq_counter.sv
// tb/tb_osc_freq_counter.sv - scoreboard bench for the oscillator frequency counter
module tb_osc_freq_counter;

  typedef struct {
    int lo;
    int hi;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic osc_in;
  int   osc_half;

  int checks;
  int errors;
  int cyc;

  exp_t q16[$];
  exp_t q8[$];
  int   done_cnt16;
  int   done_cnt8;
  int   done_cyc16[$];

  osc_freq_counter_if #(.CNT_W(16)) bus16 ();
  osc_freq_counter_if #(.CNT_W(8))  bus8 ();

  osc_freq_counter #(.CNT_W(16), .SYNC_STAGES(2), .GATE_BASE(8)) dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .bus    (bus16.slave)
  );

  osc_freq_counter #(.CNT_W(8), .SYNC_STAGES(2), .GATE_BASE(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .bus    (bus8.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    osc_in   = 1'b0;
    osc_half = 20;
    #3;
    forever #(osc_half) osc_in = ~osc_in;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks = checks + 1;
    if (act < lo || act > hi) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    exp_t e;
    done_cnt16 = 0;
    forever begin
      @(negedge clk);
      if (bus16.done === 1'b1) begin
        done_cnt16 = done_cnt16 + 1;
        done_cyc16.push_back(cyc);
        if (q16.size() == 0) begin
          chk("unexpected_done16", 1, 0, 0);
        end else begin
          e = q16.pop_front();
          chk("result16", int'(bus16.result), e.lo, e.hi);
          chk("overflow16", int'(bus16.overflow), e.ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    exp_t e;
    done_cnt8 = 0;
    forever begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        done_cnt8 = done_cnt8 + 1;
        if (q8.size() == 0) begin
          chk("unexpected_done8", 1, 0, 0);
        end else begin
          e = q8.pop_front();
          chk("result8", int'(bus8.result), e.lo, e.hi);
          chk("overflow8", int'(bus8.overflow), e.ovf, e.ovf);
        end
      end
    end
  end

  task automatic push16(input int lo, input int hi, input int ovf);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    q16.push_back(e);
  endtask

  task automatic push8(input int lo, input int hi, input int ovf);
    exp_t e;
    e.lo = lo; e.hi = hi; e.ovf = ovf;
    q8.push_back(e);
  endtask

  task automatic start16();
    @(posedge clk); #1 bus16.start = 1'b1;
    @(posedge clk); #1 bus16.start = 1'b0;
  endtask

  task automatic start8();
    @(posedge clk); #1 bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
  endtask

  // Count busy cycles until done appears on the 16-bit instance
  task automatic meas16(input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus16.busy) n++;
      if (bus16.done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1, 1);
    chk({name, "_busy_cycles"}, n, 257, 257);
  endtask

  task automatic wait_done8(input int target);
    for (int i = 0; i < 3000 && done_cnt8 < target; i++) @(negedge clk);
    #1;
    chk("done8_within_budget", done_cnt8, target, target);
  endtask

  initial begin
    int base;
    int n;
    bit seen;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus16.ena = 1'b1; bus16.start = 1'b0; bus16.cont = 1'b0; bus16.gate_sel = 3'd0;
    bus8.ena  = 1'b1; bus8.start  = 1'b0; bus8.cont  = 1'b0; bus8.gate_sel  = 3'd0;
    repeat (4) @(negedge clk);
    chk("rst_result", int'(bus16.result), 0, 0);
    chk("rst_done", int'(bus16.done), 0, 0);
    chk("rst_busy", int'(bus16.busy), 0, 0);
    chk("rst_overflow", int'(bus16.overflow), 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single measurement, clk/4 tap, shortest window
    base = done_cnt16;
    push16(63, 65, 0);
    start16();
    meas16("t1");
    repeat (50) @(negedge clk);
    #1 chk("t1_one_done", done_cnt16 - base, 1, 1);

    // Narrow counter saturates over a long window, then recovers
    bus8.gate_sel = 3'd2;
    push8(255, 255, 1);
    start8();
    wait_done8(1);
    bus8.gate_sel = 3'd0;
    repeat (5) @(posedge clk);
    push8(63, 65, 0);
    start8();
    wait_done8(2);

    // Continuous mode at clk/8; drop cont during the third window
    osc_half = 40;
    repeat (100) @(posedge clk);
    base = done_cnt16;
    push16(31, 33, 0); push16(31, 33, 0); push16(31, 33, 0);
    @(posedge clk); #1 bus16.cont = 1'b1;
    start16();
    for (int i = 0; i < 2000 && done_cnt16 < base + 2; i++) @(negedge clk);
    repeat (100) @(posedge clk);
    #1 bus16.cont = 1'b0;
    for (int i = 0; i < 2000 && done_cnt16 < base + 3; i++) @(negedge clk);
    repeat (400) @(negedge clk);
    #1;
    chk("cont_done_count", done_cnt16 - base, 3, 3);
    chk("cont_busy_after", int'(bus16.busy), 0, 0);
    if (done_cyc16.size() >= base + 3) begin
      chk("cont_period_1", done_cyc16[base+1] - done_cyc16[base], 258, 258);
      chk("cont_period_2", done_cyc16[base+2] - done_cyc16[base+1], 258, 258);
    end else begin
      chk("cont_done_history", done_cyc16.size(), base + 3, base + 3);
    end

    // start held high, then re-pulsed mid-window: one measurement, fixed length
    osc_half = 20;
    repeat (100) @(posedge clk);
    base = done_cnt16;
    push16(63, 65, 0);
    @(posedge clk); #1 bus16.start = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (i == 100) bus16.start = 1'b0;
      if (i == 110) bus16.start = 1'b1;
      if (i == 115) bus16.start = 1'b0;
      if (bus16.busy) n++;
      if (bus16.done) seen = 1'b1;
    end
    chk("t4_done_seen", int'(seen), 1, 1);
    chk("t4_busy_cycles", n, 257, 257);
    repeat (400) @(negedge clk);
    #1 chk("t4_one_done", done_cnt16 - base, 1, 1);

    // ena dropped mid-window: abort, keep old result, then a normal run
    base = done_cnt16;
    start16();
    repeat (100) @(posedge clk);
    #1 bus16.ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ena_busy_low", int'(bus16.busy), 0, 0);
    repeat (400) @(negedge clk);
    #1;
    chk("ena_no_done", done_cnt16 - base, 0, 0);
    chk("ena_result_kept", int'(bus16.result), 63, 65);
    bus16.ena = 1'b1;
    osc_half = 40;
    repeat (100) @(posedge clk);
    push16(31, 33, 0);
    start16();
    meas16("t5");

    // Asynchronous reset between clock edges in the middle of a window
    repeat (20) @(posedge clk);
    base = done_cnt16;
    start16();
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_result", int'(bus16.result), 0, 0);
    chk("arst_busy", int'(bus16.busy), 0, 0);
    chk("arst_overflow", int'(bus16.overflow), 0, 0);
    chk("arst_done", int'(bus16.done), 0, 0);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    chk("arst_busy_after", int'(bus16.busy), 0, 0);
    chk("arst_no_done", done_cnt16 - base, 0, 0);
    push16(31, 33, 0);
    start16();
    meas16("t6");

    repeat (5) @(negedge clk);
    #1;
    chk("q16_drained", q16.size(), 0, 0);
    chk("q8_drained", q8.size(), 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/osc_freq_counter.md
Name: osc_freq_counter

Overview:
Digital frequency counter that sits directly downstream of the ring-oscillator macro. It takes one oscillator tap (asynchronous to clk, already divided on-macro to below clk/2), synchronises it, and counts rising edges over a programmable gate window of clk cycles. It presents a saturating count and status flags for readout on the tile's dedicated outputs.

Parameters:
CNT_W, 16, width of the edge counter and the result register.
SYNC_STAGES, 2, number of flip-flop synchroniser stages on osc_in (minimum 2).
GATE_BASE, 8, log2 of the shortest gate window; window = 2^(GATE_BASE+gate_sel) clk cycles.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
ena  input  1  tile enable; low forces the block idle.
osc_in  input  1  oscillator tap, asynchronous to clk.
gate_sel  input  3  gate window select; sampled on ARM entry.
start  input  1  level/pulse; a high level in IDLE launches one measurement.
cont  input  1  continuous mode; high causes auto-restart after DONE.
result  output  CNT_W  last completed edge count.
done  output  1  one-cycle pulse when result updates.
busy  output  1  high in ARM and GATE.
overflow  output  1  count saturated during last measurement.

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; result=0; done=0; busy=0; overflow=0; synchroniser, edge register and counters cleared.
- Synchroniser: SYNC_STAGES flops on osc_in, then 1 history flop. edge_stb = sync & ~hist; one clk pulse per rising edge.
- FSM states: IDLE, ARM, GATE, DONE.
- IDLE -> ARM when ena & start. In ARM: latch gate_sel, clear edge count, clear internal overflow, load window counter with 2^(GATE_BASE+gate_sel)-1. ARM lasts exactly 1 cycle.
- GATE: every cycle, if edge_stb, count+1. The count saturates at 2^CNT_W-1 and sets internal overflow. Window counter decrements each cycle. When it reaches 0 (that cycle is still counted) -> DONE. GATE lasts exactly 2^(GATE_BASE+gate_sel) cycles.
- DONE (1 cycle): result<=count, overflow<=internal overflow, done=1. Next state: ARM if cont & ena, else IDLE.
- Latency: start high in cycle 0 (IDLE) -> ARM cycle 1 -> GATE cycles 2..N+1 -> DONE cycle N+2. result, done and overflow are visible from cycle N+3 (registered); done is high for exactly that cycle.
- busy is registered and high exactly while the FSM is in ARM or GATE.
- start while busy or in DONE: ignored. Measurements never retrigger or extend.
- gate_sel changes during GATE: no effect until the next ARM.
- ena low in any state: FSM returns to IDLE on the next edge. The measurement in progress is discarded. result and overflow keep their last values, and done stays 0.
- cont dropped during GATE: the current measurement completes, then the FSM goes to IDLE.
- Edges arriving in IDLE, ARM or DONE are not counted.
- Accuracy: ±1 count from synchroniser phase. osc_in at or above clk/2 is out of spec and gives no guaranteed result.

Test Plan:
- osc_in = clk/4 square, CNT_W=16, gate_sel=0, start pulse -> after 256 GATE cycles, done pulses once; result=64 (±1); overflow=0; busy high for 257 cycles.
- CNT_W=8 build, osc_in = clk/4, gate_sel=2 (1024 cycles) -> result=255, overflow=1. Follow with gate_sel=0 -> result=64, overflow=0.
- cont=1, osc_in = clk/8, gate_sel=0 -> done pulses every 258 cycles, each with result=32. Drop cont mid-GATE -> exactly one further done, then IDLE and busy=0.
- start held high and re-pulsed during GATE -> exactly one done per measurement; the window length is not extended.
- Assert rst_n low asynchronously mid-GATE (between clk edges) -> outputs go to 0 immediately. After release, busy=0 until a new start.
- ena low mid-GATE -> IDLE next cycle, no done, previous result retained. ena high plus start -> normal measurement.
